// File: rtl/intra_pkg.sv
// Shared types and frame geometry helpers for the intra-prediction front end.
// Geometry is derived from frame and macroblock sizes at elaboration time.
package intra_pkg;

    localparam int MBNUM_BITS = 13;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRED_LAUNCH,
        PRED_WAIT,
        OUTPUT,
        DONE
    } mb_sched_state_t;

    function automatic int mbs_per_row(input int length, input int mb_size_l);
        return length / mb_size_l;
    endfunction

    function automatic int mbs_per_col(input int width, input int mb_size_w);
        return width / mb_size_w;
    endfunction

    function automatic int num_mb(
        input int width,
        input int length,
        input int mb_size_l,
        input int mb_size_w
    );
        return mbs_per_row(length, mb_size_l) * mbs_per_col(width, mb_size_w);
    endfunction

endpackage

// File: rtl/mb_raster_counter.sv
// Raster-order macroblock position tracker: number, column and row.
// Column/row advance incrementally so no divider is needed.
module mb_raster_counter
    import intra_pkg::*;
#(
    parameter int MBS_PER_ROW = 80,
    parameter int NUM_MB      = 3600
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  advance,
    output logic [MBNUM_BITS-1:0] mbnumber,
    output logic [7:0]            col,
    output logic [7:0]            row,
    output logic                  last
);

    localparam logic [MBNUM_BITS-1:0] LAST_MB  = MBNUM_BITS'(NUM_MB - 1);
    localparam logic [7:0]            LAST_COL = 8'(MBS_PER_ROW - 1);

    // Position registers: clear to MB0, step one MB per advance with column wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mbnumber <= '0;
            col      <= '0;
            row      <= '0;
        end else if (clear) begin
            mbnumber <= '0;
            col      <= '0;
            row      <= '0;
        end else if (advance) begin
            mbnumber <= mbnumber + MBNUM_BITS'(1);
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

    assign last = (mbnumber == LAST_MB);

endmodule

// File: rtl/mb_scheduler.sv
// Frame-level macroblock sequencer: fetch, predict, hand off downstream.
// All outputs come from registers or decode of the registered state.
module mb_scheduler
    import intra_pkg::*;
#(
    parameter int WIDTH      = 720,
    parameter int LENGTH     = 1280,
    parameter int MB_SIZE_L  = 16,
    parameter int MB_SIZE_W  = 16,
    parameter int EXT_PULSES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  busy,
    output logic                  ext_enable,
    output logic [MBNUM_BITS-1:0] ext_mbnumber,
    output logic [7:0]            mb_col,
    output logic [7:0]            mb_row,
    output logic                  pred_start,
    input  logic                  pred_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MBNUM_BITS-1:0] out_mbnumber,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  frame_done
);

    localparam int MBS_PER_ROW = mbs_per_row(LENGTH, MB_SIZE_L);
    localparam int NUM_MB      = num_mb(WIDTH, LENGTH, MB_SIZE_L, MB_SIZE_W);

    localparam logic [4:0] PULSE_LAST = 5'(EXT_PULSES - 1);

    mb_sched_state_t       state;
    mb_sched_state_t       state_next;
    logic [4:0]            pulse_cnt;
    logic [MBNUM_BITS-1:0] mbnumber;
    logic                  last_mb;
    logic                  clear;
    logic                  handshake;

    assign clear     = (state == IDLE) && frame_start;
    assign handshake = (state == OUTPUT) && out_ready;

    mb_raster_counter #(
        .MBS_PER_ROW (MBS_PER_ROW),
        .NUM_MB      (NUM_MB)
    ) u_raster (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .advance  (handshake && !last_mb),
        .mbnumber (mbnumber),
        .col      (mb_col),
        .row      (mb_row),
        .last     (last_mb)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts extractor enable cycles within the current fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_cnt <= '0;
        end else if (state == FETCH && pulse_cnt != PULSE_LAST) begin
            pulse_cnt <= pulse_cnt + 5'd1;
        end else begin
            pulse_cnt <= '0;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        ext_enable = 1'b0;
        pred_start = 1'b0;
        out_valid  = 1'b0;
        out_first  = 1'b0;
        out_last   = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                ext_enable = 1'b1;
                if (pulse_cnt == PULSE_LAST) begin
                    state_next = PRED_LAUNCH;
                end
            end
            PRED_LAUNCH: begin
                pred_start = 1'b1;
                state_next = PRED_WAIT;
            end
            PRED_WAIT: begin
                if (pred_done) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_first = (mbnumber == '0);
                out_last  = last_mb;
                if (out_ready) begin
                    state_next = last_mb ? DONE : FETCH;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ext_mbnumber = mbnumber;
    assign out_mbnumber = mbnumber;

endmodule

// File: tb/tb_mb_scheduler.sv
// Randomised self-checking bench for mb_scheduler on a 2x2-MB frame
// and a full default-size frame.
module tb_mb_scheduler;

    localparam int S_NMB = 4;
    localparam int S_RPR = 2;
    localparam int F_NMB = 3600;
    localparam int F_RPR = 80;
    localparam int EXTP  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_reset, s_frame_start, s_pred_done, s_out_ready;
    logic        s_busy, s_ext_enable, s_pred_start, s_out_valid;
    logic        s_out_first, s_out_last, s_frame_done;
    logic [12:0] s_ext_mbnumber, s_out_mbnumber;
    logic [7:0]  s_mb_col, s_mb_row;

    logic        f_reset, f_frame_start, f_pred_done, f_out_ready;
    logic        f_busy, f_ext_enable, f_pred_start, f_out_valid;
    logic        f_out_first, f_out_last, f_frame_done;
    logic [12:0] f_ext_mbnumber, f_out_mbnumber;
    logic [7:0]  f_mb_col, f_mb_row;

    mb_scheduler #(
        .WIDTH(32), .LENGTH(32), .MB_SIZE_L(16), .MB_SIZE_W(16), .EXT_PULSES(EXTP)
    ) u_small (
        .clk(clk), .reset(s_reset), .frame_start(s_frame_start), .busy(s_busy),
        .ext_enable(s_ext_enable), .ext_mbnumber(s_ext_mbnumber),
        .mb_col(s_mb_col), .mb_row(s_mb_row),
        .pred_start(s_pred_start), .pred_done(s_pred_done),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_mbnumber(s_out_mbnumber), .out_first(s_out_first),
        .out_last(s_out_last), .frame_done(s_frame_done)
    );

    mb_scheduler u_full (
        .clk(clk), .reset(f_reset), .frame_start(f_frame_start), .busy(f_busy),
        .ext_enable(f_ext_enable), .ext_mbnumber(f_ext_mbnumber),
        .mb_col(f_mb_col), .mb_row(f_mb_row),
        .pred_start(f_pred_start), .pred_done(f_pred_done),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_mbnumber(f_out_mbnumber), .out_first(f_out_first),
        .out_last(f_out_last), .frame_done(f_frame_done)
    );

    int total = 0;
    int bad   = 0;

    // stimulus configuration (written by main process only)
    int lat_min = 1, lat_max = 1, stall_mb = -1, stall_len = 0;
    bit spur = 0, rand_ready = 0;
    int clr_req = 0;

    // observations (written by monitor process only)
    int hs_mb[$], hs_col[$], hs_row[$], hs_first[$], hs_last[$], hs_cyc[$];
    int fe_cyc[$], fe_len[$], fe_mbn[$];
    int cyc = 0, run = 0, cd = 0, clr_ack = 0, stall_left = 0;
    int ps_cnt = 0, fd_cnt = 0, hold_viol = 0, ext_in_valid = 0, stall_seen = 0;
    bit prev_stall = 0, pd = 0, rdy = 0;
    logic [12:0] prev_mbn;
    logic prev_first, prev_last;

    // Monitor plus predictor / downstream responder for the small DUT.
    initial begin
        s_pred_done = 1'b0;
        s_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req != clr_ack) begin
                clr_ack = clr_req;
                hs_mb.delete(); hs_col.delete(); hs_row.delete();
                hs_first.delete(); hs_last.delete(); hs_cyc.delete();
                fe_cyc.delete(); fe_len.delete(); fe_mbn.delete();
                run = 0; cd = 0; ps_cnt = 0; fd_cnt = 0; hold_viol = 0;
                ext_in_valid = 0; stall_seen = 0; prev_stall = 0;
                stall_left = stall_len;
            end
            if (s_ext_enable) begin
                if (run == 0) begin
                    fe_cyc.push_back(cyc);
                    fe_mbn.push_back(int'(s_ext_mbnumber));
                end else if (int'(s_ext_mbnumber) != fe_mbn[$]) begin
                    hold_viol++;
                end
                run++;
            end else if (run != 0) begin
                fe_len.push_back(run);
                run = 0;
            end
            if (s_pred_start) ps_cnt++;
            if (s_frame_done) fd_cnt++;
            if (s_out_valid && s_ext_enable) ext_in_valid++;
            if (prev_stall && (!s_out_valid || s_out_mbnumber != prev_mbn ||
                s_out_first != prev_first || s_out_last != prev_last))
                hold_viol++;
            pd = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) pd = 1'b1;
            end
            if (s_pred_start) cd = $urandom_range(lat_max, lat_min);
            if (spur && s_ext_enable) pd = 1'b1;
            s_pred_done = pd;
            rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (s_out_valid && int'(s_out_mbnumber) == stall_mb && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            s_out_ready = rdy;
            if (s_out_valid && !rdy) stall_seen++;
            prev_stall = s_out_valid && !rdy;
            prev_mbn   = s_out_mbnumber;
            prev_first = s_out_first;
            prev_last  = s_out_last;
            if (s_out_valid && rdy) begin
                hs_mb.push_back(int'(s_out_mbnumber));
                hs_col.push_back(int'(s_mb_col));
                hs_row.push_back(int'(s_mb_row));
                hs_first.push_back(int'(s_out_first));
                hs_last.push_back(int'(s_out_last));
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_mon();
        clr_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        s_frame_start = 1'b1;
        @(negedge clk);
        s_frame_start = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        for (int i = 0; i < 3000 && fd_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        ok = (fd_cnt != 0);
    endtask

    task automatic check_beats(input string tag);
        total++;
        if (hs_mb.size() != S_NMB) begin
            bad++;
            $display("FAIL %s_count: got %0d beats want %0d", tag, hs_mb.size(), S_NMB);
        end
        for (int k = 0; k < hs_mb.size(); k++) begin
            total++;
            if (hs_mb[k] !== k || hs_col[k] !== k % S_RPR || hs_row[k] !== k / S_RPR ||
                hs_first[k] !== int'(k == 0) || hs_last[k] !== int'(k == S_NMB - 1)) begin
                bad++;
                $display("FAIL %s_beat%0d: got mb=%0d col=%0d row=%0d first=%0d last=%0d want mb=%0d col=%0d row=%0d first=%0d last=%0d",
                    tag, k, hs_mb[k], hs_col[k], hs_row[k], hs_first[k], hs_last[k],
                    k, k % S_RPR, k / S_RPR, int'(k == 0), int'(k == S_NMB - 1));
            end
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++;
            $display("FAIL %s_frame_done: got %0d pulses want 1", tag, fd_cnt);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({s_busy, s_ext_enable, s_pred_start, s_out_valid, s_out_first,
             s_out_last, s_frame_done} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0", {s_busy, s_ext_enable,
                s_pred_start, s_out_valid, s_out_first, s_out_last, s_frame_done});
        end
        total++;
        if ({s_ext_mbnumber, s_out_mbnumber, s_mb_col, s_mb_row} !== 42'b0) begin
            bad++;
            $display("FAIL reset_numbers: ext=%0d out=%0d col=%0d row=%0d want 0",
                s_ext_mbnumber, s_out_mbnumber, s_mb_col, s_mb_row);
        end
        total++;
        if ({f_busy, f_ext_enable, f_out_valid, f_frame_done, f_out_mbnumber} !== 17'b0) begin
            bad++;
            $display("FAIL reset_full: busy=%0d ext=%0d valid=%0d mb=%0d want 0",
                f_busy, f_ext_enable, f_out_valid, f_out_mbnumber);
        end
        @(negedge clk);
        s_reset = 1'b0;
        f_reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (s_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy: got %0d want 0", s_busy);
        end
    endtask

    task automatic test_basic_frame();
        bit ok;
        lat_min = 1; lat_max = 1; spur = 0; stall_mb = -1; stall_len = 0; rand_ready = 0;
        clear_mon();
        pulse_start();
        wait_frame(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout: frame_done=%0d want 1", fd_cnt);
        end
        check_beats("basic");
        total++;
        if (fe_len.size() != S_NMB || ps_cnt != S_NMB) begin
            bad++;
            $display("FAIL basic_fetches: got fetches=%0d pred_starts=%0d want %0d",
                fe_len.size(), ps_cnt, S_NMB);
        end
        for (int k = 0; k < fe_len.size() && k < hs_cyc.size(); k++) begin
            total++;
            if (fe_len[k] !== EXTP || fe_mbn[k] !== k || hs_cyc[k] - fe_cyc[k] !== EXTP + 2) begin
                bad++;
                $display("FAIL basic_fetch%0d: got len=%0d mbn=%0d lat=%0d want len=%0d mbn=%0d lat=%0d",
                    k, fe_len[k], fe_mbn[k], hs_cyc[k] - fe_cyc[k], EXTP, k, EXTP + 2);
            end
        end
        total++;
        if (hold_viol !== 0) begin
            bad++;
            $display("FAIL basic_ext_hold: got %0d changes want 0", hold_viol);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        lat_min = 1; lat_max = 1; spur = 0; stall_mb = 1; stall_len = 5; rand_ready = 0;
        clear_mon();
        pulse_start();
        wait_frame(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_timeout: frame_done=%0d want 1", fd_cnt);
        end
        check_beats("bp");
        total++;
        if (stall_seen !== 5 || hold_viol !== 0 || ext_in_valid !== 0) begin
            bad++;
            $display("FAIL bp_stall: got stall=%0d hold_viol=%0d ext_in_valid=%0d want 5 0 0",
                stall_seen, hold_viol, ext_in_valid);
        end
        for (int k = 0; k + 1 < fe_cyc.size() && k < hs_cyc.size(); k++) begin
            total++;
            if (fe_cyc[k + 1] !== hs_cyc[k] + 1) begin
                bad++;
                $display("FAIL bp_next_fetch%0d: got cycle %0d want %0d",
                    k + 1, fe_cyc[k + 1], hs_cyc[k] + 1);
            end
        end
    endtask

    task automatic test_slow_pred();
        bit ok;
        lat_min = 10; lat_max = 10; spur = 1; stall_mb = -1; stall_len = 0; rand_ready = 0;
        clear_mon();
        pulse_start();
        wait_frame(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL slow_timeout: frame_done=%0d want 1", fd_cnt);
        end
        check_beats("slow");
        total++;
        if (ps_cnt !== S_NMB) begin
            bad++;
            $display("FAIL slow_pred_starts: got %0d want %0d", ps_cnt, S_NMB);
        end
        for (int k = 0; k < fe_cyc.size() && k < hs_cyc.size(); k++) begin
            total++;
            if (hs_cyc[k] - fe_cyc[k] !== EXTP + 1 + 10) begin
                bad++;
                $display("FAIL slow_latency%0d: got %0d want %0d",
                    k, hs_cyc[k] - fe_cyc[k], EXTP + 11);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int f = 0; f < 3; f++) begin
            lat_min = 1; lat_max = 6; spur = 0; stall_mb = -1; stall_len = 0; rand_ready = 1;
            clear_mon();
            pulse_start();
            wait_frame(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rand_timeout: frame %0d frame_done=%0d want 1", f, fd_cnt);
            end
            check_beats("rand");
            total++;
            if (hold_viol !== 0 || ps_cnt !== S_NMB || fe_len.size() != S_NMB) begin
                bad++;
                $display("FAIL rand_protocol: got hold_viol=%0d pred_starts=%0d fetches=%0d want 0 %0d %0d",
                    hold_viol, ps_cnt, fe_len.size(), S_NMB, S_NMB);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        lat_min = 1; lat_max = 3; spur = 0; stall_mb = -1; stall_len = 0; rand_ready = 0;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 200 && hs_mb.size() < 2; i++) @(negedge clk);
        total++;
        if (hs_mb.size() != 2) begin
            bad++;
            $display("FAIL ign_reach_mb2: got %0d beats want 2", hs_mb.size());
        end
        pulse_start();
        wait_frame(ok);
        check_beats("ign");
        clear_mon();
        pulse_start();
        wait_frame(ok);
        check_beats("restart");
    endtask

    task automatic test_mid_reset();
        bit ok;
        lat_min = 10; lat_max = 10; spur = 0; stall_mb = -1; stall_len = 0; rand_ready = 0;
        clear_mon();
        pulse_start();
        for (int i = 0; i < 300 && ps_cnt < 2; i++) @(negedge clk);
        total++;
        if (ps_cnt != 2) begin
            bad++;
            $display("FAIL mrst_reach: got pred_starts=%0d want 2", ps_cnt);
        end
        repeat (2) @(negedge clk);
        #2;
        s_reset = 1'b1;
        #1;
        total++;
        if ({s_busy, s_ext_enable, s_pred_start, s_out_valid, s_out_first,
             s_out_last, s_frame_done} !== 7'b0) begin
            bad++;
            $display("FAIL mrst_flags: got %b want 0", {s_busy, s_ext_enable,
                s_pred_start, s_out_valid, s_out_first, s_out_last, s_frame_done});
        end
        total++;
        if ({s_ext_mbnumber, s_out_mbnumber, s_mb_col, s_mb_row} !== 42'b0) begin
            bad++;
            $display("FAIL mrst_numbers: got ext=%0d out=%0d col=%0d row=%0d want 0",
                s_ext_mbnumber, s_out_mbnumber, s_mb_col, s_mb_row);
        end
        @(negedge clk);
        s_reset = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (fd_cnt !== 0 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL mrst_idle: got frame_done=%0d busy=%0d want 0 0", fd_cnt, s_busy);
        end
        lat_min = 1; lat_max = 1;
        clear_mon();
        pulse_start();
        wait_frame(ok);
        check_beats("mrst_restart");
    endtask

    task automatic test_full_frame();
        int k = 0, fd = 0, errs = 0, fcd = 0;
        int last_mb = -1, last_col = -1, last_row = -1;
        bit r;
        @(negedge clk);
        f_frame_start = 1'b1;
        @(negedge clk);
        f_frame_start = 1'b0;
        for (int c = 0; c < 40000 && fd == 0; c++) begin
            @(negedge clk);
            if (f_frame_done) fd++;
            f_pred_done = 1'b0;
            if (fcd > 0) begin
                fcd--;
                if (fcd == 0) f_pred_done = 1'b1;
            end
            if (f_pred_start) fcd = 1;
            r = ($urandom_range(0, 3) != 0);
            f_out_ready = r;
            if (f_out_valid && r) begin
                if (int'(f_out_mbnumber) != k || int'(f_mb_col) != k % F_RPR ||
                    int'(f_mb_row) != k / F_RPR || f_out_first != (k == 0) ||
                    f_out_last != (k == F_NMB - 1)) begin
                    if (errs == 0)
                        $display("full frame first bad beat %0d: mb=%0d col=%0d row=%0d",
                            k, f_out_mbnumber, f_mb_col, f_mb_row);
                    errs++;
                end
                last_mb  = int'(f_out_mbnumber);
                last_col = int'(f_mb_col);
                last_row = int'(f_mb_row);
                k++;
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (f_frame_done) fd++;
        end
        total++;
        if (k !== F_NMB) begin
            bad++;
            $display("FAIL full_count: got %0d handshakes want %0d", k, F_NMB);
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL full_beats: got %0d wrong beats want 0", errs);
        end
        total++;
        if (last_mb !== F_NMB - 1 || last_col !== 79 || last_row !== 44) begin
            bad++;
            $display("FAIL full_last: got mb=%0d col=%0d row=%0d want 3599 79 44",
                last_mb, last_col, last_row);
        end
        total++;
        if (fd !== 1 || f_busy !== 1'b0) begin
            bad++;
            $display("FAIL full_done: got frame_done=%0d busy=%0d want 1 0", fd, f_busy);
        end
    endtask

    initial begin
        s_reset = 1'b1;
        s_frame_start = 1'b0;
        f_reset = 1'b1;
        f_frame_start = 1'b0;
        f_pred_done = 1'b0;
        f_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_slow_pred();
        test_random();
        test_start_ignored();
        test_mid_reset();
        test_full_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
